// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit controller: FSM state codes and line levels.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register feeding the serial line LSB-first, plus the shared bit counter.
module uart_tx_serializer #(
   parameter int DATA_LENGTH = 8,
   localparam int CNT_W = $clog2(DATA_LENGTH)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   load,
   input  logic [DATA_LENGTH-1:0] data,
   input  logic                   shift,
   input  logic                   cnt_clr,
   input  logic                   cnt_inc,
   output logic                   ser_bit,
   output logic [CNT_W-1:0]       bit_cnt,
   output logic                   ser_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);

   logic [DATA_LENGTH-1:0] shreg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         if (load)
            shreg <= data;
         else if (shift)
            shreg <= {1'b0, shreg[DATA_LENGTH-1:1]};

         // Counter saturates at the last data bit; it never wraps.
         if (load || cnt_clr)
            bit_cnt <= '0;
         else if (cnt_inc && (bit_cnt != CNT_LAST))
            bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   assign ser_bit  = shreg[0];
   assign ser_done = (bit_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel byte as start, data LSB-first, optional
// parity (taken from the upstream parity stage) and stop bits on a registered TX_OUT.
//
// state  | meaning
// IDLE   | line high, not busy, waiting for Data_Valid
// START  | start bit (line low), one cycle
// DATA   | DATA_LENGTH data bits, LSB first
// PARITY | par_bit from the parity stage, one cycle
// STOP   | STOP_BITS cycles of line high, still busy
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_LENGTH = 8,
   parameter int STOP_BITS   = 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [DATA_LENGTH-1:0] P_DATA,
   input  logic                   Data_Valid,
   input  logic                   PAR_EN,
   input  logic                   par_bit,
   output logic                   TX_OUT,
   output logic                   busy
);

   localparam int CNT_W = $clog2(DATA_LENGTH);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   tx_state_t        state, next_state;
   logic             par_en_q;
   logic             tx_next;
   logic             load, shift, cnt_clr, cnt_inc;
   logic             ser_bit, ser_done;
   logic [CNT_W-1:0] bit_cnt;

   uart_tx_serializer #(.DATA_LENGTH(DATA_LENGTH)) u_ser (
      .CLK      (CLK),
      .RST      (RST),
      .load     (load),
      .data     (P_DATA),
      .shift    (shift),
      .cnt_clr  (cnt_clr),
      .cnt_inc  (cnt_inc),
      .ser_bit  (ser_bit),
      .bit_cnt  (bit_cnt),
      .ser_done (ser_done)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         TX_OUT   <= LINE_IDLE;
         busy     <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state  <= next_state;
         TX_OUT <= tx_next;
         busy   <= (next_state != IDLE);
         if (load)
            par_en_q <= PAR_EN;
      end
   end

   // TX_OUT is registered, so the level computed here is the one for next_state.
   always_comb begin
      next_state = state;
      tx_next    = LINE_IDLE;
      load       = 1'b0;
      shift      = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      unique case (state)
         IDLE: begin
            if (Data_Valid) begin
               next_state = START;
               tx_next    = START_BIT;
               load       = 1'b1;
            end
         end
         START: begin
            next_state = DATA;
            tx_next    = ser_bit;
            shift      = 1'b1;
         end
         DATA: begin
            if (ser_done) begin
               if (par_en_q) begin
                  next_state = PARITY;
                  tx_next    = par_bit;
               end else begin
                  next_state = STOP;
                  cnt_clr    = 1'b1;
               end
            end else begin
               tx_next = ser_bit;
               shift   = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         PARITY: begin
            next_state = STOP;
            cnt_clr    = 1'b1;
         end
         STOP: begin
            if (bit_cnt == STOP_LAST) begin
               next_state = IDLE;
               cnt_clr    = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
            cnt_clr    = 1'b1;
         end
      endcase
   end

endmodule
